// File: rtl/serial_slave_port_v3_if.sv
// Bit-serial bus between a master/interconnect and serial_slave_port_v3.
// The arbiter's split_grant travels with the master side of the bundle.
interface serial_slave_port_v3_if;
  logic mode;
  logic wr_bus;
  logic master_valid;
  logic master_ready;
  logic split_grant;
  logic rd_bus;
  logic slave_ready;
  logic slave_valid;
  logic split;
  logic slave_err;
  logic wr_done;

  modport master (
    output mode, wr_bus, master_valid, master_ready, split_grant,
    input  rd_bus, slave_ready, slave_valid, split, slave_err, wr_done
  );

  modport slave (
    input  mode, wr_bus, master_valid, master_ready, split_grant,
    output rd_bus, slave_ready, slave_valid, split, slave_err, wr_done
  );
endinterface

// File: rtl/serial_slave_port_v3.sv
// Bit-serial bus slave with internal word memory: MSB-first address/data in,
// MSB-first read data out, optional split release during the read latency.
module serial_slave_port_v3 #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_DEPTH    = 64,
  parameter int READ_LATENCY = 4,
  parameter bit SPLIT_EN     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  serial_slave_port_v3_if.slave bus
);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int MAX_AD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MAX_N  = (MAX_AD > READ_LATENCY) ? MAX_AD : READ_LATENCY;
  localparam int CNT_W  = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0]    ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]    DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]    LAT_LAST  = CNT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, WAIT, SPLIT, SEND} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic                    mode_reg;
  logic                    oor_reg;
  logic                    slave_ready_reg;
  logic                    slave_valid_reg;
  logic                    split_reg;
  logic                    slave_err_reg;
  logic                    wr_done_reg;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_q_reg;

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   addr_full;
  logic                    addr_oor;
  logic                    rd_en;
  logic                    wr_en;

  assign accept    = bus.master_valid & slave_ready_reg;
  assign addr_full = {addr_reg[ADDR_WIDTH-2:0], bus.wr_bus};
  assign addr_oor  = ({1'b0, addr_full} >= DEPTH_EXT);
  // The memory read is issued with the last address bit so the word is ready
  // even when READ_LATENCY is 1.
  assign rd_en     = (state_reg == ADDR) && accept && (cnt_reg == ADDR_LAST) && !mode_reg;
  assign wr_en     = (state_reg == WRITE) && !oor_reg;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[addr_reg[IDX_W-1:0]] <= data_reg;
    if (rd_en)
      mem_q_reg <= mem[addr_full[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      addr_reg        <= '0;
      data_reg        <= '0;
      shift_reg       <= '0;
      mode_reg        <= 1'b0;
      oor_reg         <= 1'b0;
      slave_ready_reg <= 1'b1;
      slave_valid_reg <= 1'b0;
      split_reg       <= 1'b0;
      slave_err_reg   <= 1'b0;
      wr_done_reg     <= 1'b0;
    end else begin
      wr_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= addr_full;
            mode_reg  <= bus.mode;
            cnt_reg   <= CNT_W'(1);
            state_reg <= ADDR;
          end
        end
        ADDR: begin
          if (accept) begin
            addr_reg <= addr_full;
            if (cnt_reg == ADDR_LAST) begin
              cnt_reg <= '0;
              oor_reg <= addr_oor;
              if (mode_reg) begin
                state_reg <= DATA;
              end else begin
                slave_ready_reg <= 1'b0;
                split_reg       <= SPLIT_EN;
                if (SPLIT_EN) state_reg <= SPLIT;
                else          state_reg <= WAIT;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            data_reg <= {data_reg[DATA_WIDTH-2:0], bus.wr_bus};
            if (cnt_reg == DATA_LAST) begin
              cnt_reg         <= '0;
              slave_ready_reg <= 1'b0;
              wr_done_reg     <= 1'b1;
              slave_err_reg   <= oor_reg;
              state_reg       <= WRITE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        WRITE: begin
          slave_ready_reg <= 1'b1;
          slave_err_reg   <= 1'b0;
          state_reg       <= IDLE;
        end
        WAIT, SPLIT: begin
          // Counter saturates on the last latency cycle; SPLIT then waits for grant.
          if (cnt_reg != LAT_LAST) begin
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            shift_reg <= oor_reg ? '0 : mem_q_reg;
            if (state_reg == WAIT || bus.split_grant) begin
              cnt_reg         <= '0;
              split_reg       <= 1'b0;
              slave_valid_reg <= 1'b1;
              slave_err_reg   <= oor_reg;
              state_reg       <= SEND;
            end
          end
        end
        SEND: begin
          if (bus.master_ready) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            if (cnt_reg == DATA_LAST) begin
              cnt_reg         <= '0;
              slave_valid_reg <= 1'b0;
              slave_err_reg   <= 1'b0;
              slave_ready_reg <= 1'b1;
              state_reg       <= IDLE;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.rd_bus      = shift_reg[DATA_WIDTH-1];
  assign bus.slave_ready = slave_ready_reg;
  assign bus.slave_valid = slave_valid_reg;
  assign bus.split       = split_reg;
  assign bus.slave_err   = slave_err_reg;
  assign bus.wr_done     = wr_done_reg;
endmodule

// File: tb/tb_serial_slave_port_v3.sv
// Scoreboard bench for serial_slave_port_v3: one plain instance and one with
// split enabled, driven frame by frame from a single stimulus process.
module tb_serial_slave_port_v3;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int RL    = 4;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   sel;
  logic d_mode, d_wr, d_mv, d_mr, d_grant;
  logic o_rd, o_sr, o_sv, o_split, o_err, o_wd;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [7:0] model_mem [DEPTH];

  serial_slave_port_v3_if bus0();
  serial_slave_port_v3_if bus1();

  assign bus0.mode         = (sel == 0) ? d_mode  : 1'b0;
  assign bus0.wr_bus       = (sel == 0) ? d_wr    : 1'b0;
  assign bus0.master_valid = (sel == 0) ? d_mv    : 1'b0;
  assign bus0.master_ready = (sel == 0) ? d_mr    : 1'b0;
  assign bus0.split_grant  = (sel == 0) ? d_grant : 1'b0;
  assign bus1.mode         = (sel == 1) ? d_mode  : 1'b0;
  assign bus1.wr_bus       = (sel == 1) ? d_wr    : 1'b0;
  assign bus1.master_valid = (sel == 1) ? d_mv    : 1'b0;
  assign bus1.master_ready = (sel == 1) ? d_mr    : 1'b0;
  assign bus1.split_grant  = (sel == 1) ? d_grant : 1'b0;

  assign o_rd    = (sel == 1) ? bus1.rd_bus      : bus0.rd_bus;
  assign o_sr    = (sel == 1) ? bus1.slave_ready : bus0.slave_ready;
  assign o_sv    = (sel == 1) ? bus1.slave_valid : bus0.slave_valid;
  assign o_split = (sel == 1) ? bus1.split       : bus0.split;
  assign o_err   = (sel == 1) ? bus1.slave_err   : bus0.slave_err;
  assign o_wd    = (sel == 1) ? bus1.wr_done     : bus0.wr_done;

  serial_slave_port_v3 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                         .READ_LATENCY(RL), .SPLIT_EN(1'b0))
    dut0 (.clk(clk), .rstn(rstn), .bus(bus0));

  serial_slave_port_v3 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
                         .READ_LATENCY(RL), .SPLIT_EN(1'b1))
    dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits MSB first; stall_len idle cycles are inserted before bit stall_at.
  task automatic drive_bits(input logic [31:0] val, input int n,
                            input int stall_at, input int stall_len);
    for (int i = n - 1; i >= 0; i--) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          d_mv = 1'b0;
          d_wr = ~val[i];
          tick();
        end
      end
      d_mv = 1'b1;
      d_wr = val[i];
      checks++;
      if (o_sr !== 1'b1) begin
        failures++;
        $display("FAIL bit_ready bit=%0d got=%b want=1", i, o_sr);
      end
      tick();
    end
    d_mv = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data,
                          input int a_at, input int a_len, input int d_at, input int d_len);
    logic exp_err;
    exp_err = (addr >= 16'(DEPTH));
    d_mode = 1'b1;
    drive_bits({16'h0, addr}, AW, a_at, a_len);
    d_mode = 1'b0;
    drive_bits({24'h0, data}, DW, d_at, d_len);
    checks++;
    if (o_wd !== 1'b1 || o_err !== exp_err || o_sr !== 1'b0) begin
      failures++;
      $display("FAIL write_cycle got wr_done=%b err=%b ready=%b want 1 %b 0", o_wd, o_err, o_sr, exp_err);
    end
    tick();
    checks++;
    if (o_wd !== 1'b0 || o_err !== 1'b0 || o_sr !== 1'b1) begin
      failures++;
      $display("FAIL write_after got wr_done=%b err=%b ready=%b want 0 0 1", o_wd, o_err, o_sr);
    end
    if (!exp_err) model_mem[addr[5:0]] = data;
    $display("WRITE dut=%0d addr=%h data=%h err=%b", sel, addr, data, exp_err);
  endtask

  // grant_at: cycle (counting the first WAIT cycle as 1) that raises split_grant.
  task automatic do_read(input logic [15:0] addr, input int grant_at, input bit alt_ready);
    exp_t       e;
    exp_t       x;
    int         j;
    int         k;
    int         nb;
    int         exp_first;
    logic [7:0] got_word;
    logic       prev_bit;
    bit         prev_held;
    bit         acc;
    e.err  = (addr >= 16'(DEPTH));
    e.data = e.err ? 8'h00 : model_mem[addr[5:0]];
    sb.push_back(e);
    d_mode = 1'b0;
    d_mr   = 1'b0;
    drive_bits({16'h0, addr}, AW, -1, 0);
    j = 1;
    while (j <= 40) begin
      d_grant = 1'b0;
      if (o_sv === 1'b1) break;
      checks++;
      if (o_split !== (sel == 1) || o_sr !== 1'b0) begin
        failures++;
        $display("FAIL wait_state cyc=%0d got split=%b ready=%b want %b 0", j, o_split, o_sr, (sel == 1));
      end
      if (sel == 1 && j == grant_at) d_grant = 1'b1;
      tick();
      j++;
    end
    d_grant   = 1'b0;
    exp_first = (sel == 1) ? grant_at + 1 : RL + 1;
    checks++;
    if (j !== exp_first) begin
      failures++;
      $display("FAIL send_start got=%0d want=%0d", j, exp_first);
    end
    nb = 0; k = 0; prev_held = 1'b0; prev_bit = 1'b0; got_word = 8'h00;
    while (nb < DW && k < 40) begin
      checks++;
      if (o_sv !== 1'b1 || o_err !== e.err || o_split !== 1'b0) begin
        failures++;
        $display("FAIL send_flags k=%0d got valid=%b err=%b split=%b want 1 %b 0", k, o_sv, o_err, o_split, e.err);
      end
      if (prev_held) begin
        checks++;
        if (o_rd !== prev_bit) begin
          failures++;
          $display("FAIL bit_held k=%0d got=%b want=%b", k, o_rd, prev_bit);
        end
      end
      acc  = !alt_ready || (k % 2 == 1);
      d_mr = acc;
      if (acc) begin
        got_word  = {got_word[6:0], o_rd};
        nb++;
        prev_held = 1'b0;
      end else begin
        prev_held = 1'b1;
        prev_bit  = o_rd;
      end
      tick();
      k++;
    end
    d_mr = 1'b0;
    checks++;
    if (o_sv !== 1'b0 || o_sr !== 1'b1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL send_end got valid=%b ready=%b err=%b want 0 1 0", o_sv, o_sr, o_err);
    end
    x = sb.pop_front();
    checks++;
    if (got_word !== x.data) begin
      failures++;
      $display("FAIL read_data addr=%h got=%h want=%h", addr, got_word, x.data);
    end
    $display("READ dut=%0d addr=%h data=%h err=%b", sel, addr, got_word, x.err);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if (bus0.slave_ready !== 1'b1 || bus0.slave_valid !== 1'b0 || bus0.split !== 1'b0 ||
        bus0.slave_err !== 1'b0 || bus0.wr_done !== 1'b0 || bus0.rd_bus !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0 got rdy=%b vld=%b split=%b err=%b wd=%b rd=%b want 1 0 0 0 0 0",
               bus0.slave_ready, bus0.slave_valid, bus0.split, bus0.slave_err, bus0.wr_done, bus0.rd_bus);
    end
    checks++;
    if (bus1.slave_ready !== 1'b1 || bus1.slave_valid !== 1'b0 || bus1.split !== 1'b0 ||
        bus1.slave_err !== 1'b0 || bus1.wr_done !== 1'b0 || bus1.rd_bus !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1 got rdy=%b vld=%b split=%b err=%b wd=%b rd=%b want 1 0 0 0 0 0",
               bus1.slave_ready, bus1.slave_valid, bus1.split, bus1.slave_err, bus1.wr_done, bus1.rd_bus);
    end
    rstn = 1'b1;
    tick();
    $display("RESET done");
  endtask

  task automatic test_write_read();
    sel = 0;
    do_write(16'h0003, 8'hA5, -1, 0, -1, 0);
    do_read(16'h0003, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 0;
    do_read(16'h0003, 0, 1'b1);
  endtask

  task automatic test_split();
    sel = 1;
    do_write(16'h0003, 8'hA5, -1, 0, -1, 0);
    do_read(16'h0003, 10, 1'b0);
    sel = 0;
  endtask

  task automatic test_out_of_range();
    sel = 0;
    do_write(16'h0000, 8'h11, -1, 0, -1, 0);
    do_write(16'h0040, 8'h3C, -1, 0, -1, 0);
    do_read(16'h0000, 0, 1'b0);
    do_read(16'h0040, 0, 1'b0);
  endtask

  task automatic test_stall();
    sel = 0;
    do_write(16'h0007, 8'h5A, 9, 3, 4, 2);
    do_read(16'h0007, 0, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    sel    = 0;
    d_mode = 1'b1;
    drive_bits(32'h0007, AW, -1, 0);
    d_mode = 1'b0;
    drive_bits(32'h0000, 4, -1, 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if (o_sr !== 1'b1 || o_wd !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got ready=%b wr_done=%b want 1 0", o_sr, o_wd);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_wd === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL mid_reset_wr_done got=%0d want=0", pulses);
    end
    $display("RESET mid-frame write abandoned");
    do_read(16'h0007, 0, 1'b0);
  endtask

  initial begin
    sel = 0;
    d_mode = 1'b0; d_wr = 1'b0; d_mv = 1'b0; d_mr = 1'b0; d_grant = 1'b0;
    rstn = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_split();
    test_out_of_range();
    test_stall();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
